crc_32_tx_framer: RTL and testbench

- Byte-stream framer directly upstream of the crc_32 engine.
- Accepts payload bytes on a valid/ready/last interface and forwards them unchanged downstream.
- Drives run/clear/data_in of an internal crc_32 instance, then appends the 4-byte FCS taken from crc_out.
- Used on the BIST signature/transmit path so every emitted frame carries its own checksum.

---
 rtl/crc_pkg.sv | 30 +++
 rtl/crc_32.sv | 27 ++
 rtl/crc_32_tx_framer.sv | 153 +++++++++++++++
 tb/tb_crc_32_tx_framer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC-32 transmit framer and its CRC engine.
package crc_pkg;

  // Framer sequencing: payload pass-through, then the four FCS bytes LSB first.
  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
    FCS0,
    FCS1,
    FCS2,
    FCS3
  } framer_state_t;

  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam int          FCS_BYTES     = 4;
  // IEEE 802.3 polynomial in reflected (LSB-first) form.
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  // Advance the reflected CRC register by one byte, bit 0 of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_32.sv
// Byte-wide Ethernet CRC-32 engine. crc_out is the finished (inverted) value,
// so a freshly cleared engine reads 0x0000_0000.
module crc_32
  import crc_pkg::*;
(
  input  logic        mclk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        run,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] crc_q;

  // Running CRC register: clear dominates, otherwise fold in one byte per run.
  always_ff @(posedge mclk) begin
    if (!reset_n || clear) begin
      crc_q <= CRC_INIT;
    end else if (run) begin
      crc_q <= crc32_byte(crc_q, data_in);
    end
  end

  assign crc_out = ~crc_q;

endmodule

// File: rtl/crc_32_tx_framer.sv
// Transmit framer: passes payload bytes straight through with zero latency
// while feeding the CRC engine, then appends the 4-byte FCS (LSB byte first).
module crc_32_tx_framer
  import crc_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int MAX_LEN = 1518
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             abort,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic             frame_done,
  output logic [LEN_W-1:0] frame_len,
  output logic             len_err
);

  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
  localparam int               IDX_W     = $clog2(FCS_BYTES);

  framer_state_t    state;
  framer_state_t    state_nxt;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] count_nxt;
  logic [LEN_W-1:0] count_inc;
  logic [LEN_W-1:0] frame_len_nxt;
  logic             len_err_nxt;

  logic             pay_phase;
  logic             pay_hs;
  logic             fcs_last_hs;
  logic [31:0]      crc_out;
  logic [IDX_W-1:0] fcs_idx;
  logic [7:0]       fcs_byte;

  assign pay_phase   = (state == IDLE) || (state == PAYLOAD);
  // s_ready and m_valid are already forced low under reset/abort, so these
  // handshakes can never fire in a reset or abort cycle.
  assign pay_hs      = s_valid & s_ready;
  assign fcs_last_hs = m_valid & m_ready & m_last;
  assign count_inc   = count + LEN_W'(1);

  crc_32 u_crc (
    .mclk    (mclk),
    .reset_n (1'b1),
    .clear   (reset | abort | fcs_last_hs),
    .run     (pay_hs),
    .data_in (s_data),
    .crc_out (crc_out)
  );

  // Select which FCS byte is on the wire; crc_out is frozen while run is low.
  always_comb begin
    fcs_idx = '0;
    case (state)
      FCS1:    fcs_idx = IDX_W'(1);
      FCS2:    fcs_idx = IDX_W'(2);
      FCS3:    fcs_idx = IDX_W'(3);
      default: fcs_idx = '0;
    endcase
  end

  assign fcs_byte = crc_out[{fcs_idx, 3'b000} +: 8];

  // Output stage: combinational pass-through during payload, FCS bytes after.
  always_comb begin
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    m_data     = 8'h00;
    m_last     = 1'b0;
    frame_done = 1'b0;
    if (!reset && !abort) begin
      if (pay_phase) begin
        s_ready = m_ready;
        m_valid = s_valid;
        m_data  = s_data;
      end else begin
        m_valid    = 1'b1;
        m_data     = fcs_byte;
        m_last     = (state == FCS3);
        frame_done = (state == FCS3) && m_ready;
      end
    end
  end

  // Next-state logic; abort overrides everything and keeps frame_len/len_err.
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    frame_len_nxt = frame_len;
    len_err_nxt   = len_err;
    case (state)
      IDLE, PAYLOAD: begin
        if (pay_hs) begin
          count_nxt = count_inc;
          // count_inc is the number of this byte; reaching MAX_LEN without
          // s_last means the frame would overflow, so close it here.
          if (s_last || (count_inc == MAX_LEN_C)) begin
            state_nxt     = FCS0;
            frame_len_nxt = count_inc;
            if (!s_last) begin
              len_err_nxt = 1'b1;
            end
          end else begin
            state_nxt = PAYLOAD;
          end
        end
      end
      FCS0: if (m_valid && m_ready) state_nxt = FCS1;
      FCS1: if (m_valid && m_ready) state_nxt = FCS2;
      FCS2: if (m_valid && m_ready) state_nxt = FCS3;
      FCS3: begin
        if (m_valid && m_ready) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
    if (abort) begin
      state_nxt     = IDLE;
      count_nxt     = '0;
      frame_len_nxt = frame_len;
      len_err_nxt   = len_err;
    end
  end

  // Control registers.
  always_ff @(posedge mclk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      frame_len <= '0;
      len_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      frame_len <= frame_len_nxt;
      len_err   <= len_err_nxt;
    end
  end

endmodule

// File: tb/tb_crc_32_tx_framer.sv
// Directed bench for crc_32_tx_framer with a scoreboard of expected output
// bytes and an independent (non-reflected, MSB-first) CRC-32 reference.
module tb_crc_32_tx_framer;
  import crc_pkg::*;

  localparam int LEN_W      = 16;
  // Small enough that the overflow scenario stays short; a 9-byte frame with
  // s_last exactly at the limit must still be legal.
  localparam int TB_MAX_LEN = 9;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       fcs;
  } exp_t;

  logic             mclk = 1'b0;
  logic             reset;
  logic [7:0]       s_data;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic             abort;
  logic [7:0]       m_data;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;
  logic             frame_done;
  logic [LEN_W-1:0] frame_len;
  logic             len_err;

  exp_t       sb[$];
  logic [7:0] fb[$];
  int         n_checks = 0;
  int         n_errs   = 0;
  int         n_done   = 0;
  int         done0;
  logic       tog_en   = 1'b0;
  logic [3:0] pat      = 4'b1001;
  int         ph       = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       hs_seen   = 1'b0;
  logic [31:0] c6;

  always #5 mclk = ~mclk;

  crc_32_tx_framer #(
    .LEN_W   (LEN_W),
    .MAX_LEN (TB_MAX_LEN)
  ) dut (
    .mclk       (mclk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .abort      (abort),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .len_err    (len_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errs++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference CRC-32: non-reflected shift register fed with bit-reversed bytes.
  function automatic logic [31:0] model_crc(input logic [7:0] b[$]);
    logic [31:0] c;
    logic [31:0] r;
    logic [7:0]  rb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < b.size(); i++) begin
      for (int k = 0; k < 8; k++) rb[k] = b[i][7-k];
      c = c ^ {rb, 24'h0};
      for (int k = 0; k < 8; k++) begin
        c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
      end
    end
    for (int k = 0; k < 32; k++) r[k] = c[31-k];
    return ~r;
  endfunction

  task automatic push(input logic [7:0] d, input logic last, input logic fcs);
    exp_t e;
    e.d    = d;
    e.last = last;
    e.fcs  = fcs;
    sb.push_back(e);
  endtask

  task automatic push_fcs();
    logic [31:0] c;
    c = model_crc(fb);
    for (int i = 0; i < 4; i++) push(c[8*i +: 8], (i == 3), 1'b1);
    fb.delete();
  endtask

  // Output-side checks, sampled on the falling edge.
  task automatic monitor();
    exp_t e;
    if (prev_hold && !reset && !abort) begin
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_data", 32'(m_data), 32'(prev_data));
    end
    if (m_valid && sb.size() > 0 && sb[0].fcs) begin
      check("fcs_sready", 32'(s_ready), 32'd0);
    end
    check("frame_done", 32'(frame_done), 32'(m_valid & m_ready & m_last));
    if (frame_done) n_done++;
    if (m_valid && m_ready) begin
      check("out_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("m_data", 32'(m_data), 32'(e.d));
        check("m_last", 32'(m_last), 32'(e.last));
      end
    end
    prev_hold = m_valid & ~m_ready;
    prev_data = m_data;
  endtask

  task automatic tick();
    @(negedge mclk);
    hs_seen = s_valid & s_ready;
    monitor();
    @(posedge mclk);
    #1;
    m_ready = tog_en ? pat[ph] : 1'b1;
    ph = (ph + 1) % 4;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    push(d, 1'b0, 1'b0);
    fb.push_back(d);
    hs_seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (hs_seen) break;
    end
    check("s_handshake", 32'(hs_seen), 32'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    tick();
    tick();
    check("drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    abort   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hAA;
    s_last  = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(posedge mclk);
    @(negedge mclk);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_len", 32'(frame_len), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_crc", dut.u_crc.crc_out, 32'h0000_0000);
    @(posedge mclk);
    #1;
    reset   = 1'b0;
    s_valid = 1'b0;

    // 1: "123456789", full-rate downstream.
    done0 = n_done;
    for (int i = 1; i <= 9; i++) send_byte(8'(8'h30 + i), (i == 9));
    check("t1_crc_known", dut.u_crc.crc_out, 32'hCBF4_3926);
    check("t1_state_fcs0", 32'(dut.state), 32'(FCS0));
    push_fcs();
    wait_drain();
    check("t1_done_cnt", 32'(n_done - done0), 32'd1);
    check("t1_frame_len", 32'(frame_len), 32'd9);
    check("t1_len_err", 32'(len_err), 32'd0);

    // 2: same frame with downstream backpressure 1,0,0,1.
    tog_en = 1'b1;
    done0  = n_done;
    for (int i = 1; i <= 9; i++) send_byte(8'(8'h30 + i), (i == 9));
    push_fcs();
    wait_drain();
    tog_en = 1'b0;
    tick();
    check("t2_done_cnt", 32'(n_done - done0), 32'd1);
    check("t2_frame_len", 32'(frame_len), 32'd9);

    // 3: single-byte frame.
    done0 = n_done;
    send_byte(8'hA5, 1'b1);
    check("t3_state_fcs0", 32'(dut.state), 32'(FCS0));
    push_fcs();
    wait_drain();
    check("t3_done_cnt", 32'(n_done - done0), 32'd1);
    check("t3_frame_len", 32'(frame_len), 32'd1);

    // 4: abort frame A after 3 bytes, then frame B.
    done0 = n_done;
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    fb.delete();
    s_data  = 8'h77;
    s_valid = 1'b1;
    abort   = 1'b1;
    @(negedge mclk);
    check("t4_abort_mvalid", 32'(m_valid), 32'd0);
    check("t4_abort_sready", 32'(s_ready), 32'd0);
    prev_hold = 1'b0;
    @(posedge mclk);
    #1;
    abort   = 1'b0;
    s_valid = 1'b0;
    check("t4_state_idle", 32'(dut.state), 32'(IDLE));
    check("t4_crc_cleared", dut.u_crc.crc_out, 32'h0000_0000);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b1);
    push_fcs();
    wait_drain();
    check("t4_done_cnt", 32'(n_done - done0), 32'd1);
    check("t4_frame_len", 32'(frame_len), 32'd2);

    // 5: 11 bytes with s_last on the 11th; the limit cuts after byte 9.
    done0 = n_done;
    for (int i = 1; i <= 9; i++) send_byte(8'(8'h40 + i), 1'b0);
    check("t5_state_fcs0", 32'(dut.state), 32'(FCS0));
    push_fcs();
    send_byte(8'h4A, 1'b0);
    check("t5_ovf_frame_len", 32'(frame_len), 32'd9);
    check("t5_ovf_len_err", 32'(len_err), 32'd1);
    send_byte(8'h4B, 1'b1);
    push_fcs();
    wait_drain();
    check("t5_done_cnt", 32'(n_done - done0), 32'd2);
    check("t5_frame_len", 32'(frame_len), 32'd2);
    check("t5_len_err_sticky", 32'(len_err), 32'd1);

    // 6: reset during FCS1, then a clean frame.
    done0 = n_done;
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h30, 1'b1);
    c6 = model_crc(fb);
    push(c6[7:0], 1'b0, 1'b1);
    fb.delete();
    tick();
    check("t6_state_fcs1", 32'(dut.state), 32'(FCS1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_m_valid", 32'(m_valid), 32'd0);
    check("t6_state_idle", 32'(dut.state), 32'(IDLE));
    check("t6_crc_zero", dut.u_crc.crc_out, 32'h0000_0000);
    check("t6_len_err_clr", 32'(len_err), 32'd0);
    check("t6_frame_len_clr", 32'(frame_len), 32'd0);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);
    check("t6_no_done", 32'(n_done - done0), 32'd0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'hC3, 1'b1);
    push_fcs();
    wait_drain();
    check("t6_done_cnt", 32'(n_done - done0), 32'd1);
    check("t6_frame_len", 32'(frame_len), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
